// File: rtl/sample_stream_player.sv
// sample_stream_player: paced FIFO-to-PWM playback with gain, saturation and underrun counting; define PLAYER_FADE_EN for a fade-out over the last 256 samples.
module sample_stream_player #(
  parameter int DIV = 1042,
  parameter int LEN_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic [3:0]       gain,
  input  logic [15:0]      fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [15:0]      sample_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       underrun_cnt
);
  localparam int CW = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, PLAY, CAPT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [LEN_W-1:0] remaining;
  logic [3:0] gain_q;
  logic tick;
  logic signed [20:0] p, ps;
  logic signed [15:0] scaled, shaped;
  assign tick = cnt == CW'(DIV - 1);
  assign p = 21'($signed(fifo_dout)) * 21'($signed({1'b0, gain_q}));
  assign ps = p >>> 3;
  assign scaled = ps > 21'sd32767 ? 16'sh7fff : ps < -21'sd32768 ? 16'sh8000 : ps[15:0];
`ifdef PLAYER_FADE_EN
  logic signed [24:0] f;
  assign f = 25'(scaled) * $signed({17'b0, remaining[7:0]});
  assign shaped = remaining < LEN_W'(256) ? 16'(f >>> 8) : scaled;
`else
  assign shaped = scaled;
`endif
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: if (start) state_n = length == '0 ? DONE : PLAY;
      PLAY: if (tick) begin
        if (remaining == '0) state_n = DONE;
        else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_n = CAPT;
        end
      end
      CAPT: state_n = PLAY;
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      remaining <= '0;
      gain_q <= '0;
      sample_out <= 16'h8000;
      done <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state <= state_n;
      done <= state == DONE;
      cnt <= (state == PLAY || state == CAPT) && !tick ? cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        remaining <= length;
        gain_q <= gain;
        underrun_cnt <= '0;
      end
      // an empty FIFO on a tick still consumes one sample slot
      if (state == PLAY && tick && remaining != '0 && fifo_empty) begin
        remaining <= remaining - 1'b1;
        underrun_cnt <= underrun_cnt + {7'b0, underrun_cnt != 8'hff};
      end
      if (state == CAPT) begin
        sample_out <= shaped ^ 16'h8000;
        remaining <= remaining - 1'b1;
      end
      if (state == DONE) sample_out <= 16'h8000;
    end
  end
endmodule

// File: tb/tb_sample_stream_player.sv
// tb_sample_stream_player: directed, table-driven checks of playback timing, gain/saturation, underruns and reset.
module tb_sample_stream_player;
  localparam int DIV = 8;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [19:0] length = '0;
  logic [3:0] gain = '0;
  logic [15:0] fifo_dout = '0;
  logic fifo_empty, fifo_rd_en, busy, done;
  logic [15:0] sample_out;
  logic [7:0] underrun_cnt;
  logic [15:0] mem [1024];
  int wr_ptr = 0, rd_ptr = 0, rd_cnt = 0, base = 0;
  int checks = 0, failures = 0;
  typedef struct { logic [3:0] g; logic [15:0] din; logic [15:0] exp; } vec_t;
  vec_t tbl [9];

  sample_stream_player #(.DIV(DIV), .LEN_W(20)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length), .gain(gain),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .sample_out(sample_out), .busy(busy), .done(done), .underrun_cnt(underrun_cnt)
  );

  always #10 clk = ~clk;
  assign fifo_empty = rd_ptr == wr_ptr;
  always @(posedge clk)
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr[9:0]];
      rd_ptr <= rd_ptr + 1;
      rd_cnt <= rd_cnt + 1;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d);
    mem[wr_ptr[9:0]] = d;
    wr_ptr++;
  endtask

  // leaves the bench at the negedge just after the start edge
  task automatic play(input logic [19:0] len, input logic [3:0] g);
    @(negedge clk);
    start = 1'b1;
    length = len;
    gain = g;
    base = rd_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] e;
    tbl[0] = '{4'd15, 16'h4000, 16'hF800};
    tbl[1] = '{4'd15, 16'hC000, 16'h0800};
    tbl[2] = '{4'd15, 16'h7FFF, 16'hFFFF};
    tbl[3] = '{4'd15, 16'h8000, 16'h0000};
    tbl[4] = '{4'd0,  16'h7FFF, 16'h8000};
    tbl[5] = '{4'd1,  16'h0010, 16'h8002};
    tbl[6] = '{4'd4,  16'hFFF0, 16'h7FF8};
    tbl[7] = '{4'd3,  16'hFFFF, 16'h7FFF};
    tbl[8] = '{4'd9,  16'h7200, 16'hFFFF};

    tick_n(3);
    chk("rst_sample", sample_out, 16'h8000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_underrun", underrun_cnt, 0);
    reset = 1'b0;

    push(16'h1111); push(16'h2222); push(16'h3333);
    play(3, 8);
    tick_n(12);
    chk("pre_reset_sample", sample_out, 16'h9111);
    reset = 1'b1;
    tick_n(1);
    chk("midrst_sample", sample_out, 16'h8000);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", fifo_rd_en, 0);
    chk("midrst_done", done, 0);
    chk("midrst_underrun", underrun_cnt, 0);
    reset = 1'b0;
    wr_ptr = rd_ptr;

    push(16'h1234); push(16'hFFFF); push(16'h8000);
    play(3, 8);
    gain = 4'd0;
    chk("main_busy", busy, 1);
    chk("main_underrun_clr", underrun_cnt, 0);
    tick_n(7);
    chk("main_rd_tick1", fifo_rd_en, 1);
    tick_n(1);
    chk("main_rd_single", fifo_rd_en, 0);
    tick_n(1);
    chk("main_s0", sample_out, 16'h9234);
    tick_n(7);
    chk("main_s0_hold", sample_out, 16'h9234);
    tick_n(1);
    chk("main_s1", sample_out, 16'h7FFF);
    start = 1'b1;
    length = 20'd50;
    tick_n(1);
    start = 1'b0;
    tick_n(7);
    chk("main_s2", sample_out, 16'h0000);
    tick_n(7);
    chk("main_pre_done", done, 0);
    chk("main_pre_done_busy", busy, 1);
    tick_n(1);
    chk("main_done", done, 1);
    chk("main_done_busy", busy, 0);
    chk("main_silence", sample_out, 16'h8000);
    chk("main_reads", rd_cnt - base, 3);
    tick_n(1);
    chk("main_done_pulse", done, 0);
    chk("main_no_restart", busy, 0);

    foreach (tbl[i]) begin
      push(tbl[i].din);
      play(1, tbl[i].g);
      tick_n(9);
      chk($sformatf("gain%0d_sample", i), sample_out, tbl[i].exp);
      tick_n(8);
      chk($sformatf("gain%0d_done", i), done, 1);
      chk($sformatf("gain%0d_silence", i), sample_out, 16'h8000);
      chk($sformatf("gain%0d_reads", i), rd_cnt - base, 1);
    end

    push(16'h1000);
    play(5, 8);
    tick_n(9);
    chk("ur_s0", sample_out, 16'h9000);
    tick_n(15);
    chk("ur_count", underrun_cnt, 2);
    chk("ur_hold", sample_out, 16'h9000);
    push(16'h2000); push(16'h3000);
    tick_n(9);
    chk("ur_s1", sample_out, 16'hA000);
    tick_n(8);
    chk("ur_s2", sample_out, 16'hB000);
    tick_n(7);
    chk("ur_pre_done", done, 0);
    tick_n(1);
    chk("ur_done", done, 1);
    chk("ur_reads", rd_cnt - base, 3);
    chk("ur_count_final", underrun_cnt, 2);

    play(260, 8);
    for (int i = 0; i < 2400 && !done; i++) @(negedge clk);
    chk("sat_done_timeout", done, 1);
    chk("sat_underrun", underrun_cnt, 8'hFF);
    chk("sat_reads", rd_cnt - base, 0);

    play(0, 8);
    chk("len0_underrun_clr", underrun_cnt, 0);
    chk("len0_busy", busy, 1);
    chk("len0_not_done", done, 0);
    tick_n(1);
    chk("len0_done", done, 1);
    chk("len0_busy_fall", busy, 0);
    chk("len0_silence", sample_out, 16'h8000);
    chk("len0_reads", rd_cnt - base, 0);

    for (int k = 0; k < 300; k++) push(16'h4000);
    play(300, 8);
    for (int k = 0; k < 300; k++) begin
      int r;
      tick_n(k == 0 ? 9 : 8);
      r = 300 - k;
`ifdef PLAYER_FADE_EN
      e = r < 256 ? 16'((16384 * r) >> 8) ^ 16'h8000 : 16'hC000;
`else
      e = 16'hC000;
`endif
      chk($sformatf("fade_r%0d", r), sample_out, e);
    end
    tick_n(8);
    chk("fade_done", done, 1);
    chk("fade_reads", rd_cnt - base, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
